ifu_ctrl: RTL and testbench
===========================

# ifu_ctrl

Instruction-fetch sequencer that owns the program counter of the NPC core and drives one instruction at a time through instruction memory to decode/execute. It issues fetch requests over a valid/ready port, captures the response, presents the instruction downstream, and computes the next PC on retirement: sequential (+4), jal/branch (PC-relative, offset<<1) or jalr (absolute). Misaligned targets and halt requests stop fetching.

## Interface
- RESET_PC, 32'h80000000, PC loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  fetch address (= current PC)
- imem_resp_valid  in  1  fetch data valid
- imem_resp_data  in  32  fetched instruction word
- inst_valid  out  1  instruction presented downstream
- inst_ready  in  1  downstream retires instruction this cycle
- inst_data  out  32  registered instruction word
- inst_pc  out  32  PC of inst_data
- redir_valid  in  1  retiring instruction changes control flow (sampled only on retire)
- redir_kind  in  2  00 jal, 01 jalr, 10 branch taken, 11 reserved (treated as sequential)
- redir_offset  in  32  jal/branch: signed halfword offset; jalr: absolute target
- halt  in  1  retiring instruction is ebreak (sampled only on retire)
- halted  out  1  sticky, fetch stopped by halt
- misalign_err  out  1  sticky, redirect target not 4-byte aligned
- bad_target  out  32  offending target captured with misalign_err
- instret  out  32  retired-instruction counter

## Operation
- States: REQ, WAIT, HOLD, HALT, ERR. Reset -> REQ, PC=RESET_PC.
- REQ: imem_req_valid=1, imem_req_addr=PC. On imem_req_ready -> WAIT.
- WAIT: on imem_resp_valid capture inst_data<=imem_resp_data, inst_pc<=PC -> HOLD.
- HOLD: inst_valid=1. Retire = inst_valid & inst_ready.
- On retire, next-PC target T:
  - redir_valid=0 or kind=11: T=PC+4
  - jal / branch: T=PC+(redir_offset<<1), mod 2^32
  - jalr: T=redir_offset & ~32'h1
- Retire priority: halt > misalign > normal.
  - halt=1: PC unchanged, halted<=1, -> HALT.
  - T[1:0]!=0: misalign_err<=1, bad_target<=T, PC unchanged, -> ERR.
  - else PC<=T, -> REQ.
- instret increments by 1 on every retire (including the halting and faulting one); wraps 32'hFFFFFFFF -> 0.
- HALT, ERR: no requests, inst_valid=0; left only by rst.
- imem_resp_valid outside WAIT ignored; redir_*/halt outside retire ignored.

## Timing
- Reset values: PC=RESET_PC, imem_req_valid=1 (REQ state), inst_valid=0, inst_data=0, inst_pc=RESET_PC, halted=0, misalign_err=0, bad_target=0, instret=0.
- rst asynchronous: outputs take reset values immediately on assertion, mid-request/mid-hold included; a response arriving after reset release while in REQ is ignored.
- imem_req_addr and imem_req_valid held stable while valid & !ready.
- Response accepted earliest the cycle after request acceptance (never same cycle).
- Zero-wait memory: request accepted cycle N, response N+1, inst_valid N+2, retire N+2 earliest, next request N+3 -> 3 cycles/instruction minimum.
- inst_data/inst_pc stable for all of HOLD.
- Retire updates PC, instret, halted, misalign_err on the same edge; flags visible the following cycle.

## Test plan
- Reset release, zero-wait memory, 4 sequential retires -> addresses 0x80000000, 0x80000004, 0x80000008, 0x8000000C; instret=4; 3-cycle spacing between requests.
- imem_req_ready low 5 cycles, resp delayed 3 cycles -> address stable throughout, single capture, inst_pc correct.
- Retire at PC 0x80000010 with jal offset 0xFFFFFFF8 -> next fetch 0x80000000; branch offset 0x10 -> 0x80000030; jalr offset 0x80000101 -> 0x80000100.
- jalr to 0x80000102 -> misalign_err=1, bad_target=0x80000102, no further requests, instret incremented.
- halt with redir_valid=1 on same retire -> halted=1, misalign_err=0, no further requests.
- rst asserted in WAIT and again in HOLD -> immediate return to REQ at 0x80000000, stale response ignored; instret preset near 32'hFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/ifu_ctrl_if.sv
// Fetch-sequencer port bundle: imem request/response, downstream instruction, retire feedback, status.
// master = sequencer side, slave = memory/decode environment side.
interface ifu_ctrl_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_offset;
  logic        halt;
  logic        halted;
  logic        misalign_err;
  logic [31:0] bad_target;
  logic [31:0] instret;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           halted, misalign_err, bad_target, instret,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redir_valid, redir_kind, redir_offset, halt
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
           halted, misalign_err, bad_target, instret,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redir_valid, redir_kind, redir_offset, halt
  );
endinterface

// File: rtl/ifu_ctrl.sv
// Single-outstanding fetch sequencer owning the PC; 3 cycles/instruction minimum with zero-wait memory.
// Request held stable until imem_req_ready; instruction held until inst_ready retires it.
module ifu_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic        clk,
  input logic        rst,
  ifu_ctrl_if.master bus
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_HALT, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] bad_target_q, bad_target_d;
  logic [31:0] instret_q, instret_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;

  logic        retire;
  logic        tgt_misaligned;
  logic [31:0] target;

  assign retire = (state_q == S_HOLD) && bus.inst_ready;

  // Reserved kind and non-redirecting retires fall through to the sequential target.
  always_comb begin
    target = pc_q + 32'd4;
    if (bus.redir_valid) begin
      case (bus.redir_kind)
        2'b00, 2'b10: target = pc_q + {bus.redir_offset[30:0], 1'b0};
        2'b01:        target = {bus.redir_offset[31:1], 1'b0};
        default:      target = pc_q + 32'd4;
      endcase
    end
  end

  assign tgt_misaligned = (target[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_data_q  <= 32'd0;
      inst_pc_q    <= RESET_PC;
      bad_target_q <= 32'd0;
      instret_q    <= 32'd0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      bad_target_q <= bad_target_d;
      instret_q    <= instret_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:  if (bus.imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (bus.imem_resp_valid) state_d = S_HOLD;
      S_HOLD: begin
        if (retire) begin
          if (bus.halt)             state_d = S_HALT;
          else if (tgt_misaligned)  state_d = S_ERR;
          else                      state_d = S_REQ;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Halt wins over a faulting redirect on the same retire; both leave the PC untouched.
  always_comb begin
    pc_d         = pc_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    bad_target_d = bad_target_q;
    instret_d    = instret_q;
    halted_d     = halted_q;
    misalign_d   = misalign_q;
    if ((state_q == S_WAIT) && bus.imem_resp_valid) begin
      inst_data_d = bus.imem_resp_data;
      inst_pc_d   = pc_q;
    end
    if (retire) begin
      instret_d = instret_q + 32'd1;
      if (bus.halt) begin
        halted_d = 1'b1;
      end else if (tgt_misaligned) begin
        misalign_d   = 1'b1;
        bad_target_d = target;
      end else begin
        pc_d = target;
      end
    end
  end

  always_comb begin
    bus.imem_req_valid = (state_q == S_REQ);
    bus.inst_valid     = (state_q == S_HOLD);
  end

  assign bus.imem_req_addr = pc_q;
  assign bus.inst_data     = inst_data_q;
  assign bus.inst_pc       = inst_pc_q;
  assign bus.halted        = halted_q;
  assign bus.misalign_err  = misalign_q;
  assign bus.bad_target    = bad_target_q;
  assign bus.instret       = instret_q;

endmodule

// File: tb/tb_ifu_ctrl.sv
// Bench for ifu_ctrl: directed sequences, a redirect vector table and randomized traffic vs. a PC/flag model.
module tb_ifu_ctrl;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ifu_ctrl_if bus();

  ifu_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model: what the fetch unit must look like after each retire.
  logic [31:0] pc_m, instret_m, bad_m;
  logic        halted_m, err_m;

  typedef struct {
    logic        rv;
    logic [1:0]  kind;
    logic [31:0] off;
    logic        h;
    logic [31:0] exp_addr;
    logic        exp_halt;
    logic        exp_err;
    logic [31:0] exp_bad;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] next_target(input logic [31:0] pc, input logic rv,
                                              input logic [1:0] kind, input logic [31:0] off);
    if (!rv || kind == 2'b11) return pc + 32'd4;
    if (kind == 2'b01) return off - (off % 2);
    return pc + off * 32'd2;
  endfunction

  task automatic model_reset();
    pc_m = RST_PC; instret_m = 0; bad_m = 0; halted_m = 0; err_m = 0;
  endtask

  task automatic model_retire(input logic rv, input logic [1:0] kind, input logic [31:0] off, input logic h);
    logic [31:0] t;
    t = next_target(pc_m, rv, kind, off);
    instret_m = instret_m + 1;
    if (h) halted_m = 1'b1;
    else if (t % 4 != 0) begin err_m = 1'b1; bad_m = t; end
    else pc_m = t;
  endtask

  task automatic junk_redir();
    bus.redir_valid  = 1'($urandom);
    bus.redir_kind   = 2'($urandom);
    bus.redir_offset = $urandom;
    bus.halt         = 1'($urandom);
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
    bus.inst_ready = 0; bus.redir_valid = 0; bus.redir_kind = 0; bus.redir_offset = 0; bus.halt = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 1);
    check({tag, "_req_addr"}, bus.imem_req_addr, RST_PC);
    check({tag, "_inst_valid"}, 32'(bus.inst_valid), 0);
    check({tag, "_inst_data"}, bus.inst_data, 0);
    check({tag, "_inst_pc"}, bus.inst_pc, RST_PC);
    check({tag, "_halted"}, 32'(bus.halted), 0);
    check({tag, "_misalign"}, 32'(bus.misalign_err), 0);
    check({tag, "_bad_target"}, bus.bad_target, 0);
    check({tag, "_instret"}, bus.instret, 0);
  endtask

  // Called at a negedge; asserts reset between edges and releases it at the next negedge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  task automatic req_phase(input int rdy_dly, input bit junk, output logic [31:0] addr, output int acc);
    int n = 0;
    addr = 32'hx; acc = 0;
    while (!bus.imem_req_valid && n < 40) begin @(negedge clk); n++; end
    if (!bus.imem_req_valid) begin fail_timeout("req_wait"); return; end
    addr = bus.imem_req_addr;
    check("req_addr", addr, pc_m);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_resp_valid = junk; bus.imem_resp_data = 32'hDEAD_BEEF;
      @(negedge clk);
      check("req_hold_valid", 32'(bus.imem_req_valid), 1);
      check("req_hold_addr", bus.imem_req_addr, addr);
    end
    bus.imem_req_ready = 1; bus.imem_resp_valid = junk; bus.imem_resp_data = 32'hDEAD_BEEF;
    acc = cyc;
    @(negedge clk);
    bus.imem_req_ready = 0; bus.imem_resp_valid = 0;
    check("req_dropped", 32'(bus.imem_req_valid), 0);
    check("no_early_capture", 32'(bus.inst_valid), 0);
  endtask

  task automatic resp_phase(input int resp_dly, input logic [31:0] word);
    for (int i = 0; i < resp_dly; i++) begin
      @(negedge clk);
      check("wait_no_inst", {31'd0, bus.inst_valid | bus.imem_req_valid}, 0);
    end
    bus.imem_resp_valid = 1; bus.imem_resp_data = word;
    @(negedge clk);
    bus.imem_resp_valid = 0; bus.imem_resp_data = $urandom;
    check("hold_valid", 32'(bus.inst_valid), 1);
    check("hold_data", bus.inst_data, word);
    check("hold_pc", bus.inst_pc, pc_m);
  endtask

  task automatic retire_phase(input int dly, input logic [31:0] word, input logic rv,
                              input logic [1:0] kind, input logic [31:0] off, input logic h);
    for (int i = 0; i < dly; i++) begin
      junk_redir();
      bus.imem_resp_valid = 1'($urandom);
      @(negedge clk);
      check("hold_stable", {bus.inst_data ^ word}, 0);
      check("hold_still_valid", 32'(bus.inst_valid), 1);
    end
    bus.imem_resp_valid = 0;
    bus.inst_ready = 1; bus.redir_valid = rv; bus.redir_kind = kind; bus.redir_offset = off; bus.halt = h;
    @(negedge clk);
    bus.inst_ready = 0;
    junk_redir();
    model_retire(rv, kind, off, h);
    check("instret", bus.instret, instret_m);
    check("halted", 32'(bus.halted), 32'(halted_m));
    check("misalign_err", 32'(bus.misalign_err), 32'(err_m));
    check("bad_target", bus.bad_target, bad_m);
    check("req_after_retire", 32'(bus.imem_req_valid), 32'(!(halted_m || err_m)));
    check("inst_after_retire", 32'(bus.inst_valid), 0);
  endtask

  task automatic instr(input int rdy, input int rsp, input int ret, input bit junk,
                       input logic rv, input logic [1:0] kind, input logic [31:0] off, input logic h,
                       output logic [31:0] addr, output int acc);
    logic [31:0] word;
    word = $urandom;
    req_phase(rdy, junk, addr, acc);
    resp_phase(rsp, word);
    retire_phase(ret, word, rv, kind, off, h);
  endtask

  // Terminal states must ignore every stimulus and keep the counters frozen.
  task automatic check_stuck(input int n);
    for (int i = 0; i < n; i++) begin
      bus.imem_req_ready = 1; bus.imem_resp_valid = 1; bus.inst_ready = 1; junk_redir();
      @(negedge clk);
      check("stuck_quiet", {30'd0, bus.imem_req_valid, bus.inst_valid}, 0);
    end
    idle_inputs();
    check("stuck_instret", bus.instret, instret_m);
  endtask

  initial begin
    logic [31:0] addr;
    int          acc, prev_acc;
    int          tb_halts;

    vecs[0]  = '{1'b1, 2'b00, 32'hFFFF_FFF8, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 2'b10, 32'h0000_0010, 1'b0, 32'h8000_0030, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 2'b01, 32'h8000_0101, 1'b0, 32'h8000_0100, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 2'b00, 32'h0000_0040, 1'b0, 32'h8000_0014, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 2'b11, 32'h0000_0040, 1'b0, 32'h8000_0014, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 32'h1234_5678, 1'b0, 32'h8000_0014, 1'b0, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 2'b10, 32'h8000_0000, 1'b0, 32'h8000_0010, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 2'b01, 32'h8000_0102, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0102};
    vecs[8]  = '{1'b1, 2'b00, 32'h0000_0001, 1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0012};
    vecs[9]  = '{1'b1, 2'b01, 32'h8000_0102, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 2'b00, 32'h0000_0000, 1'b1, 32'h0,         1'b1, 1'b0, 32'h0};

    idle_inputs();
    model_reset();
    @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;

    // Zero-wait memory, four sequential retires, minimum 3-cycle spacing.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
      check("seq_addr", addr, RST_PC + 32'(4 * i));
      if (i > 0) check("seq_spacing", 32'(acc - prev_acc), 3);
      prev_acc = acc;
    end
    check("seq_instret", bus.instret, 4);

    // Stalled request and delayed response with junk responses outside WAIT.
    instr(5, 3, 2, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
    check("stall_addr", addr, 32'h8000_0010);

    // Redirect table, each entry retired at PC 0x80000010.
    foreach (vecs[k]) begin
      do_reset("vec_rst");
      for (int i = 0; i < 4; i++) instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
      instr(1, 1, 1, 1'b0, vecs[k].rv, vecs[k].kind, vecs[k].off, vecs[k].h, addr, acc);
      check("vec_instret", bus.instret, 5);
      check("vec_halted", 32'(bus.halted), 32'(vecs[k].exp_halt));
      check("vec_misalign", 32'(bus.misalign_err), 32'(vecs[k].exp_err));
      check("vec_bad_target", bus.bad_target, vecs[k].exp_bad);
      if (vecs[k].exp_halt || vecs[k].exp_err) check_stuck(4);
      else check("vec_next_addr", bus.imem_req_addr, vecs[k].exp_addr);
    end

    // Reset while waiting for a response; a late response in REQ must be ignored.
    do_reset("pre_wait");
    req_phase(0, 1'b0, addr, acc);
    do_reset("rst_in_wait");
    bus.imem_resp_valid = 1; bus.imem_resp_data = 32'hBAD0_BAD0;
    repeat (2) @(negedge clk);
    bus.imem_resp_valid = 0;
    check("stale_ignored", 32'(bus.inst_valid), 0);
    check("stale_data", bus.inst_data, 0);
    check("stale_req_addr", bus.imem_req_addr, RST_PC);
    instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
    check("after_wait_rst_addr", addr, RST_PC);

    // Reset while an instruction is held downstream.
    req_phase(0, 1'b0, addr, acc);
    resp_phase(0, 32'h0000_0013);
    do_reset("rst_in_hold");
    instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
    check("after_hold_rst_addr", addr, RST_PC);

    // instret wrap from a preset near the top of its range.
    do_reset("wrap_rst");
    force dut.instret_q = 32'hFFFF_FFFE;
    #1 release dut.instret_q;
    instret_m = 32'hFFFF_FFFE;
    instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
    instr(0, 0, 0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b0, addr, acc);
    check("instret_wrapped", bus.instret, 0);

    // Randomized traffic against the model.
    do_reset("rand_rst");
    tb_halts = 0;
    for (int n = 0; n < 150; n++) begin
      logic        rv, h, bad;
      logic [1:0]  kind;
      logic [31:0] off;
      rv   = 1'($urandom);
      kind = 2'($urandom);
      h    = ($urandom_range(0, 19) == 0);
      bad  = ($urandom_range(0, 15) == 0);
      if (kind == 2'b01) off = bad ? ($urandom | 32'h2) : ($urandom & ~32'h2);
      else               off = (32'($urandom_range(0, 63)) * 32'd2 - 32'd64) | 32'(bad);
      instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
            rv, kind, off, h, addr, acc);
      if (halted_m || err_m) begin
        tb_halts++;
        check_stuck(3);
        do_reset("rand_rst");
      end
    end
    check("rand_alive", 32'(bus.imem_req_valid | bus.inst_valid | (tb_halts >= 0)), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
